// File: rtl/wb_timer_pkg.sv
// Shared constants and types for the wb_timer Wishbone machine timer.
// Register offsets, CTRL bit positions, handshake state type and a byte-lane merge helper.
package wb_timer_pkg;

    localparam logic [4:0] MTIME_LO_OFS    = 5'h00;
    localparam logic [4:0] MTIME_HI_OFS    = 5'h04;
    localparam logic [4:0] MTIMECMP_LO_OFS = 5'h08;
    localparam logic [4:0] MTIMECMP_HI_OFS = 5'h0C;
    localparam logic [4:0] CTRL_OFS        = 5'h10;
    localparam logic [4:0] PRESCALE_OFS    = 5'h14;

    localparam int CTRL_EN_BIT     = 0;
    localparam int CTRL_IRQ_EN_BIT = 1;

    localparam logic [63:0] MTIMECMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF;

    typedef enum logic {
        IDLE,
        RESP
    } wb_state_e;

    // Merge new_val into old_val only on the byte lanes selected by sel.
    function automatic logic [31:0] apply_sel(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  sel);
        logic [31:0] res;
        res = old_val;
        for (int i = 0; i < 4; i++) begin
            if (sel[i]) res[8*i +: 8] = new_val[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/wb_timer_if.sv
// Wishbone classic slave-side bundle for wb_timer; master drives requests, slave terminates.
interface wb_timer_if #(
    parameter int WB_ADDR_WIDTH = 32
);
    logic [WB_ADDR_WIDTH-1:0] WBS_ADR_I;
    logic                     WBS_WE_I;
    logic [31:0]              WBS_DAT_I;
    logic [3:0]               WBS_SEL_I;
    logic                     WBS_CYC_I;
    logic                     WBS_STB_I;
    logic [31:0]              WBS_DAT_O;
    logic                     WBS_ACK_O;
    logic                     WBS_ERR_O;

    modport master (
        output WBS_ADR_I, WBS_WE_I, WBS_DAT_I, WBS_SEL_I, WBS_CYC_I, WBS_STB_I,
        input  WBS_DAT_O, WBS_ACK_O, WBS_ERR_O
    );

    modport slave (
        input  WBS_ADR_I, WBS_WE_I, WBS_DAT_I, WBS_SEL_I, WBS_CYC_I, WBS_STB_I,
        output WBS_DAT_O, WBS_ACK_O, WBS_ERR_O
    );
endinterface

// File: rtl/timer_prescaler.sv
// Prescaler for wb_timer: emits a one-cycle tick every (prescale+1) enabled cycles.
// A clear restarts the count from zero; the count holds while disabled.
module timer_prescaler #(
    parameter int PRESCALE_WIDTH = 16
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_en,
    input  logic                      i_clr,
    input  logic [PRESCALE_WIDTH-1:0] i_prescale,
    output logic                      o_tick
);
    logic [PRESCALE_WIDTH-1:0] r_count;
    logic                      w_hit;

    assign w_hit  = (r_count == i_prescale);
    assign o_tick = i_en && w_hit;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= w_hit ? '0 : r_count + PRESCALE_WIDTH'(1);
        end
    end
endmodule

// File: rtl/wb_timer.sv
// Wishbone classic slave exposing a 64-bit mtime/mtimecmp machine timer with level IRQ.
// Define TIMER_SNAPSHOT_EN to make MTIME_HI reads return the upper half captured by the last MTIME_LO read.
module wb_timer #(
    parameter int WB_ADDR_WIDTH  = 32,
    parameter int PRESCALE_WIDTH = 16
) (
    input  logic       CLK_I,
    input  logic       RST_I,
    wb_timer_if.slave  wbs,
    output logic       IRQ_O
);
    import wb_timer_pkg::*;

    wb_state_e                 r_state;
    logic                      r_ack;
    logic                      r_err;
    logic [31:0]               r_dat_o;
    logic [63:0]               r_mtime;
    logic [63:0]               r_mtimecmp;
    logic [1:0]                r_ctrl;
    logic [PRESCALE_WIDTH-1:0] r_prescale;
    logic                      r_irq;

    logic [4:0]                w_ofs;
    logic                      w_req;
    logic                      w_valid;
    logic                      w_wr;
    logic                      w_rd;
    logic                      w_tick;
    logic [31:0]               w_rd_data;
    logic [PRESCALE_WIDTH-1:0] w_prescale_next;
    logic                      w_unused_adr;

    assign w_ofs        = wbs.WBS_ADR_I[4:0];
    assign w_unused_adr = ^wbs.WBS_ADR_I[WB_ADDR_WIDTH-1:5];
    assign w_req        = (r_state == IDLE) && wbs.WBS_CYC_I && wbs.WBS_STB_I;
    assign w_valid      = (w_ofs[1:0] == 2'b00) && (w_ofs <= PRESCALE_OFS);
    assign w_wr         = w_req && w_valid && wbs.WBS_WE_I;
    assign w_rd         = w_req && w_valid && !wbs.WBS_WE_I;

    timer_prescaler #(.PRESCALE_WIDTH(PRESCALE_WIDTH)) u_prescaler (
        .i_clk      (CLK_I),
        .i_rst_n    (RST_I),
        .i_en       (r_ctrl[CTRL_EN_BIT]),
        .i_clr      (w_wr && (w_ofs == PRESCALE_OFS)),
        .i_prescale (r_prescale),
        .o_tick     (w_tick)
    );

    // PRESCALE may be narrower than a word, so lanes are merged bit by bit.
    for (genvar gi = 0; gi < PRESCALE_WIDTH; gi++) begin : g_prescale_lane
        assign w_prescale_next[gi] = wbs.WBS_SEL_I[gi/8] ? wbs.WBS_DAT_I[gi] : r_prescale[gi];
    end

`ifdef TIMER_SNAPSHOT_EN
    logic [31:0] r_snap;

    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            r_snap <= '0;
        end else if (w_rd && (w_ofs == MTIME_LO_OFS)) begin
            r_snap <= r_mtime[63:32];
        end
    end
`endif

    always_comb begin
        w_rd_data = '0;
        case (w_ofs)
            MTIME_LO_OFS:    w_rd_data = r_mtime[31:0];
`ifdef TIMER_SNAPSHOT_EN
            MTIME_HI_OFS:    w_rd_data = r_snap;
`else
            MTIME_HI_OFS:    w_rd_data = r_mtime[63:32];
`endif
            MTIMECMP_LO_OFS: w_rd_data = r_mtimecmp[31:0];
            MTIMECMP_HI_OFS: w_rd_data = r_mtimecmp[63:32];
            CTRL_OFS:        w_rd_data = {30'd0, r_ctrl};
            PRESCALE_OFS:    w_rd_data = 32'(r_prescale);
            default:         w_rd_data = '0;
        endcase
    end

    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            r_state <= IDLE;
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
            r_dat_o <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_req) begin
                        r_state <= RESP;
                        r_ack   <= w_valid;
                        r_err   <= !w_valid;
                        r_dat_o <= w_rd ? w_rd_data : 32'd0;
                    end
                end
                RESP: begin
                    r_state <= IDLE;
                    r_ack   <= 1'b0;
                    r_err   <= 1'b0;
                    r_dat_o <= '0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // A software write to either mtime half takes precedence over the tick for that cycle.
    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            r_mtime    <= '0;
            r_mtimecmp <= MTIMECMP_RESET;
            r_ctrl     <= '0;
            r_prescale <= '0;
            r_irq      <= 1'b0;
        end else begin
            if (w_wr && (w_ofs == MTIME_LO_OFS)) begin
                r_mtime[31:0] <= apply_sel(r_mtime[31:0], wbs.WBS_DAT_I, wbs.WBS_SEL_I);
            end else if (w_wr && (w_ofs == MTIME_HI_OFS)) begin
                r_mtime[63:32] <= apply_sel(r_mtime[63:32], wbs.WBS_DAT_I, wbs.WBS_SEL_I);
            end else if (w_tick) begin
                r_mtime <= r_mtime + 64'd1;
            end
            if (w_wr && (w_ofs == MTIMECMP_LO_OFS)) begin
                r_mtimecmp[31:0] <= apply_sel(r_mtimecmp[31:0], wbs.WBS_DAT_I, wbs.WBS_SEL_I);
            end
            if (w_wr && (w_ofs == MTIMECMP_HI_OFS)) begin
                r_mtimecmp[63:32] <= apply_sel(r_mtimecmp[63:32], wbs.WBS_DAT_I, wbs.WBS_SEL_I);
            end
            if (w_wr && (w_ofs == CTRL_OFS) && wbs.WBS_SEL_I[0]) begin
                r_ctrl <= wbs.WBS_DAT_I[1:0];
            end
            if (w_wr && (w_ofs == PRESCALE_OFS)) begin
                r_prescale <= w_prescale_next;
            end
            r_irq <= r_ctrl[CTRL_IRQ_EN_BIT] && (r_mtime >= r_mtimecmp);
        end
    end

    assign wbs.WBS_ACK_O = r_ack;
    assign wbs.WBS_ERR_O = r_err;
    assign wbs.WBS_DAT_O = r_dat_o;
    assign IRQ_O         = r_irq;
endmodule

// File: tb/tb_wb_timer.sv
// Self-checking bench for wb_timer: directed bus steps plus randomized counting runs
// checked against an arithmetic model of mtime (elapsed cycles divided by prescale period).
module tb_wb_timer;
    localparam logic [31:0] A_MTIME_LO = 32'h00;
    localparam logic [31:0] A_MTIME_HI = 32'h04;
    localparam logic [31:0] A_CMP_LO   = 32'h08;
    localparam logic [31:0] A_CMP_HI   = 32'h0C;
    localparam logic [31:0] A_CTRL     = 32'h10;
    localparam logic [31:0] A_PRESCALE = 32'h14;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic irq;
    int   checks = 0;
    int   failures = 0;
    int   cyc_cnt = 0;
    int   acc_edge = 0;

    // Model of a counting run: mtime after edge n = base + (n - start) / (prescale + 1).
    logic [63:0] m_base;
    int          m_p;
    int          m_e;

    wb_timer_if #(.WB_ADDR_WIDTH(32)) bus ();

    wb_timer #(.WB_ADDR_WIDTH(32), .PRESCALE_WIDTH(16)) dut (
        .CLK_I (clk),
        .RST_I (rst_n),
        .wbs   (bus),
        .IRQ_O (irq)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    function automatic logic [63:0] model_mtime(input int n);
        return m_base + 64'((n - m_e) / (m_p + 1));
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic xfer(input logic [31:0] adr, input logic we, input logic [31:0] dat,
                        input logic [3:0] sel, input logic exp_err, output logic [31:0] rdata);
        @(negedge clk);
        bus.WBS_ADR_I = adr;
        bus.WBS_WE_I  = we;
        bus.WBS_DAT_I = dat;
        bus.WBS_SEL_I = sel;
        bus.WBS_CYC_I = 1'b1;
        bus.WBS_STB_I = 1'b1;
        @(posedge clk);
        #1;
        acc_edge = cyc_cnt;
        rdata = bus.WBS_DAT_O;
        chk($sformatf("ack@%h", adr), bus.WBS_ACK_O, !exp_err);
        chk($sformatf("err@%h", adr), bus.WBS_ERR_O, exp_err);
        if (exp_err) chk($sformatf("errdat@%h", adr), bus.WBS_DAT_O, 0);
        bus.WBS_CYC_I = 1'b0;
        bus.WBS_STB_I = 1'b0;
        bus.WBS_WE_I  = 1'b0;
        @(posedge clk);
        #1;
        chk($sformatf("oneshot@%h", adr), {bus.WBS_ACK_O, bus.WBS_ERR_O}, 0);
    endtask

    task automatic wr(input logic [31:0] adr, input logic [31:0] dat);
        logic [31:0] d;
        xfer(adr, 1'b1, dat, 4'hF, 1'b0, d);
    endtask

    task automatic rd_chk(input string tag, input logic [31:0] adr, input logic [31:0] exp);
        logic [31:0] d;
        xfer(adr, 1'b0, 32'h0, 4'hF, 1'b0, d);
        chk(tag, d, exp);
    endtask

    task automatic start_count(input logic [63:0] base, input int p, input logic [1:0] ctrl);
        wr(A_CTRL, 32'h0);
        wr(A_PRESCALE, 32'(p));
        wr(A_MTIME_LO, base[31:0]);
        wr(A_MTIME_HI, base[63:32]);
        wr(A_CTRL, {30'd0, ctrl});
        m_base = base;
        m_p    = p;
        m_e    = acc_edge;
    endtask

    // Reads LO then HI and checks both halves against the model.
    task automatic check_mtime_pair(input string tag);
        logic [31:0] lo, hi;
        logic [63:0] exp_lo, exp_hi;
        xfer(A_MTIME_LO, 1'b0, 32'h0, 4'hF, 1'b0, lo);
        exp_lo = model_mtime(acc_edge - 1);
        xfer(A_MTIME_HI, 1'b0, 32'h0, 4'hF, 1'b0, hi);
`ifndef TIMER_SNAPSHOT_EN
        exp_hi = model_mtime(acc_edge - 1);
`else
        exp_hi = exp_lo;
`endif
        chk({tag, "_lo"}, lo, {32'd0, exp_lo[31:0]});
        chk({tag, "_hi"}, hi, {32'd0, exp_hi[63:32]});
    endtask

    initial begin
        logic [31:0] d;
        logic [63:0] frozen;
        bus.WBS_ADR_I = '0;
        bus.WBS_WE_I  = 1'b0;
        bus.WBS_DAT_I = '0;
        bus.WBS_SEL_I = '0;
        bus.WBS_CYC_I = 1'b0;
        bus.WBS_STB_I = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ack", bus.WBS_ACK_O, 0);
        chk("rst_err", bus.WBS_ERR_O, 0);
        chk("rst_dat", bus.WBS_DAT_O, 0);
        chk("rst_irq", irq, 0);
        @(negedge clk);
        rst_n = 1'b1;
        rd_chk("rst_cmp_lo", A_CMP_LO, 32'hFFFF_FFFF);
        rd_chk("rst_cmp_hi", A_CMP_HI, 32'hFFFF_FFFF);
        rd_chk("rst_ctrl", A_CTRL, 32'h0);
        rd_chk("rst_prescale", A_PRESCALE, 32'h0);
        rd_chk("rst_mtime_lo", A_MTIME_LO, 32'h0);
        rd_chk("rst_mtime_hi", A_MTIME_HI, 32'h0);
        chk("rst_irq2", irq, 0);

        // Byte lanes and unimplemented bits
        xfer(A_CMP_LO, 1'b1, 32'h0000_AB00, 4'b0010, 1'b0, d);
        rd_chk("sel_byte1", A_CMP_LO, 32'hFFFF_ABFF);
        xfer(A_CMP_HI, 1'b1, 32'h1234_5678, 4'b0000, 1'b0, d);
        rd_chk("sel_none", A_CMP_HI, 32'hFFFF_FFFF);
        wr(A_PRESCALE, 32'hFFFF_FFFF);
        rd_chk("prescale_mask", A_PRESCALE, 32'h0000_FFFF);
        wr(A_CTRL, 32'hFFFF_FFFC);
        rd_chk("ctrl_mask", A_CTRL, 32'h0);

        // PRESCALE=3 for 40 cycles: mtime advances every 4th cycle
        start_count(64'd0, 3, 2'b01);
        repeat (40) @(posedge clk);
        xfer(A_MTIME_LO, 1'b0, 32'h0, 4'hF, 1'b0, d);
        frozen = model_mtime(acc_edge - 1);
        chk("ps3_lo", d, {32'd0, frozen[31:0]});
        start_count(64'd100, 0, 2'b01);
        repeat (7) @(posedge clk);
        check_mtime_pair("ps0");

        // Low-to-high carry and full 64-bit wrap
        start_count(64'h0000_0000_FFFF_FFFE, 0, 2'b01);
        check_mtime_pair("carry");
        start_count(64'hFFFF_FFFF_FFFF_FFFE, 0, 2'b01);
        check_mtime_pair("wrap64");

        // Randomized counting runs
        for (int i = 0; i < 6; i++) begin
            start_count({$urandom, $urandom}, int'($urandom_range(0, 4)), 2'b01);
            repeat ($urandom_range(0, 30)) @(posedge clk);
            check_mtime_pair($sformatf("rnd%0d", i));
        end

        // Disabling holds mtime
        wr(A_CTRL, 32'h0);
        frozen = model_mtime(acc_edge);
        repeat (10) @(posedge clk);
        rd_chk("hold_lo", A_MTIME_LO, frozen[31:0]);
        rd_chk("hold_hi", A_MTIME_HI, frozen[63:32]);

        // Interrupt tracks mtime >= mtimecmp one cycle late
        wr(A_CMP_HI, 32'h0);
        wr(A_CMP_LO, 32'd20);
        start_count(64'($urandom_range(0, 8)), int'($urandom_range(0, 2)), 2'b11);
        for (int k = 0; k < 80; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("irq_c%0d", k), irq, model_mtime(cyc_cnt - 1) >= 64'd20);
        end
        chk("irq_high", irq, 1);
        wr(A_CMP_LO, 32'hFFFF_FFFF);
        chk("irq_clear", irq, 0);
        wr(A_CMP_LO, 32'h0);
        chk("irq_reassert", irq, 1);
        wr(A_CTRL, 32'h1);
        chk("irq_masked", irq, 0);

        // Error terminations leave registers untouched
        wr(A_CTRL, 32'h0);
        frozen = model_mtime(acc_edge);
        wr(A_CMP_LO, 32'h1111_2222);
        wr(A_PRESCALE, 32'h0000_0042);
        xfer(32'h02, 1'b0, 32'h0, 4'hF, 1'b1, d);
        xfer(32'h18, 1'b0, 32'h0, 4'hF, 1'b1, d);
        xfer(32'h1C, 1'b1, 32'h1234, 4'hF, 1'b1, d);
        xfer(32'h09, 1'b1, 32'h0, 4'hF, 1'b1, d);
        xfer(32'h16, 1'b1, 32'hFFFF, 4'hF, 1'b1, d);
        xfer(32'h11, 1'b1, 32'h3, 4'hF, 1'b1, d);
        rd_chk("err_cmp_lo", A_CMP_LO, 32'h1111_2222);
        rd_chk("err_prescale", A_PRESCALE, 32'h0000_0042);
        rd_chk("err_ctrl", A_CTRL, 32'h0);
        rd_chk("err_mtime_lo", A_MTIME_LO, frozen[31:0]);

        // Reset asserted during the response cycle of a write
        @(negedge clk);
        bus.WBS_ADR_I = A_CMP_HI;
        bus.WBS_WE_I  = 1'b1;
        bus.WBS_DAT_I = 32'hAAAA_5555;
        bus.WBS_SEL_I = 4'hF;
        bus.WBS_CYC_I = 1'b1;
        bus.WBS_STB_I = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_ack_before", bus.WBS_ACK_O, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_ack_drop", bus.WBS_ACK_O, 0);
        chk("mid_err", bus.WBS_ERR_O, 0);
        chk("mid_dat", bus.WBS_DAT_O, 0);
        chk("mid_irq", irq, 0);
        bus.WBS_CYC_I = 1'b0;
        bus.WBS_STB_I = 1'b0;
        bus.WBS_WE_I  = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        rd_chk("mid_cmp_hi", A_CMP_HI, 32'hFFFF_FFFF);
        rd_chk("mid_cmp_lo", A_CMP_LO, 32'hFFFF_FFFF);
        rd_chk("mid_prescale", A_PRESCALE, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/wb_timer.md
Name: wb_timer

Overview:
Wishbone classic slave (responder) giving the CPU a 64-bit machine timer with compare interrupt. It sits beside wb_ram and wb_uart behind wb_interconnect and answers transactions issued by cpu_wb_mem_master. It provides a free-running mtime counter with a prescaler, a 64-bit mtimecmp register and a level interrupt output.

Parameters:
WB_ADDR_WIDTH, 32, width of WBS_ADR_I
PRESCALE_WIDTH, 16, width of PRESCALE register and prescaler counter

Ports:
CLK_I  in  1  clock
RST_I  in  1  reset; asynchronous assert, active-low
WBS_ADR_I  in  WB_ADDR_WIDTH  byte address; only bits [4:0] are decoded (interconnect selects this slave)
WBS_WE_I  in  1  write enable
WBS_DAT_I  in  32  write data
WBS_SEL_I  in  4  byte lane select
WBS_CYC_I  in  1  bus cycle
WBS_STB_I  in  1  strobe
WBS_DAT_O  out  32  read data, valid while WBS_ACK_O=1
WBS_ACK_O  out  1  normal termination
WBS_ERR_O  out  1  error termination
IRQ_O  out  1  timer interrupt, level

Behaviour:
- Register map, word aligned:
  - 0x00 MTIME_LO
  - 0x04 MTIME_HI
  - 0x08 MTIMECMP_LO
  - 0x0C MTIMECMP_HI
  - 0x10 CTRL: bit0 EN, bit1 IRQ_EN, others read 0 and are ignored on write
  - 0x14 PRESCALE: [PRESCALE_WIDTH-1:0], upper bits read 0
  - 0x18 and 0x1C are unmapped.
- Reset values while RST_I=0:
  - mtime=0, mtimecmp=64'hFFFF_FFFF_FFFF_FFFF, CTRL=0, PRESCALE=0, prescaler count=0.
  - WBS_ACK_O=0, WBS_ERR_O=0, WBS_DAT_O=0, IRQ_O=0, FSM=IDLE.
- Handshake FSM with states IDLE and RESP:
  - IDLE: when CYC&STB=1, latch the request and go to RESP. ACK or ERR goes high the next cycle, so latency is 1 cycle.
  - RESP: exactly one of ACK or ERR is high for exactly one cycle, then return to IDLE. No request is accepted in RESP, so there is at least one idle cycle between terminations.
  - ERR is raised for ADR[1:0]!=0 or an unmapped offset. On error, the write is discarded and DAT_O=0.
  - Writes commit on the clock edge that raises ACK, per SEL byte lane; SEL=0 gives ACK with no change.
  - Reads register DAT_O alongside ACK. The value is sampled at the IDLE->RESP edge.
  - If CYC drops while in RESP, the termination still pulses and is ignored by the master. No state is corrupted.
- Prescaler and counter:
  - When EN=1, the prescaler count increments every cycle. When count==PRESCALE, a tick is generated, count returns to 0, and mtime increments.
  - PRESCALE=0 gives a tick every cycle. mtime wraps from 2^64-1 to 0.
  - When EN=0, count and mtime hold.
  - Writing PRESCALE resets the count to 0.
  - A software write to MTIME_LO or MTIME_HI in the same cycle as a tick: the write wins for the written lanes, and the other half holds with no increment that cycle.
  - A 32-bit LO write does not carry into HI.
- Interrupt:
  - IRQ_O is registered as IRQ_EN & (mtime >= mtimecmp), an unsigned 64-bit compare. It updates one cycle after mtime, mtimecmp or CTRL change.
  - There is no latch; writing mtimecmp above mtime clears IRQ_O on the following cycle.
- Reset asserted mid-transaction aborts immediately: all outputs go to reset values and no write commits.

Optional Feature:
TIMER_SNAPSHOT_EN
- Defined: a read of MTIME_LO also captures mtime[63:32] into a snapshot register, and reads of MTIME_HI return the snapshot, giving a coherent 64-bit read with LO read first. The snapshot resets to 0. Writes to MTIME_HI still update live mtime.
- Undefined: MTIME_HI reads return live mtime[63:32]. No snapshot register exists.

Decomposition:
- Package wb_timer_pkg holds:
  - register offset localparams (MTIME_LO_OFS..PRESCALE_OFS)
  - CTRL bit index constants (CTRL_EN_BIT=0, CTRL_IRQ_EN_BIT=1)
  - FSM state enum typedef (IDLE, RESP)
  - MTIMECMP_RESET constant
- One natural sub-module, timer_prescaler: EN, PRESCALE and a clear input in, a one-cycle TICK out. Bus FSM, registers and compare stay in wb_timer.

Test Plan:
- Reset then read 0x08/0x0C -> ACK after 1 cycle, DAT_O=0xFFFF_FFFF both; read 0x10 -> 0; IRQ_O=0.
- Write PRESCALE=3, CTRL=1, wait 40 cycles, read MTIME_LO -> 10 (±1 allowing for the write/read pipeline); with PRESCALE=0 mtime advances 1 per cycle.
- Write MTIMECMP_HI=0, MTIMECMP_LO=20, CTRL=3 -> IRQ_O rises one cycle after mtime reaches 20; write MTIMECMP_LO=0xFFFF_FFFF -> IRQ_O falls next cycle.
- Write MTIME_LO=0xFFFF_FFFE, MTIME_HI=0, PRESCALE=0, EN=1 -> after 2 ticks, HI=1 and LO=0; with the macro, an LO read then HI read across the wrap returns consistent halves.
- Read 0x02, read 0x18, write 0x1C=0x1234 -> ERR pulses one cycle each, no ACK, registers unchanged.
- Byte write SEL=4'b0010, DAT=0x0000_AB00 to MTIMECMP_LO -> reads back 0xFFFF_ABFF; assert RST_I low during a write's RESP cycle -> ACK drops immediately, register unchanged.
